gcd_stein_seq: RTL and testbench

- Parametrised sequential binary GCD (Stein's algorithm) engine with valid/ready handshakes on input and output.
- Generalises the fixed 3-bit GCD3 to WIDTH bits. Corrects the iteration to single-bit shifts. Adds explicit zero-operand handling, a done handshake and result holding.
- Sits in the arithmetic datapath as a multi-cycle coprocessor. One operation in flight at a time.

---
 rtl/gcd_pkg.sv | 28 ++
 rtl/gcd_stein_step.sv | 55 +++++
 rtl/gcd_stein_seq.sv | 113 +++++++++++
 tb/tb_gcd_stein_seq.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/gcd_pkg.sv
// ============================================================================
// Module  : gcd_pkg
// Purpose : Shared state encoding and width helpers for the Stein GCD engine.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package gcd_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REDUCE = 2'd1,
    DONE   = 2'd2
  } gcd_state_t;

  // Width of the common power-of-two exponent k.
  function automatic int k_width(input int w);
    return $clog2(w + 1);
  endfunction

  // Width of the optional REDUCE-cycle counter.
  function automatic int cnt_width(input int w);
    return $clog2(2 * w + 3);
  endfunction

endpackage

`default_nettype wire

// File: rtl/gcd_stein_step.sv
// ============================================================================
// Module  : gcd_stein_step
// Purpose : Purely combinational single REDUCE step of binary (Stein) GCD.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module gcd_stein_step
  import gcd_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int KW    = k_width(WIDTH)
) (
  input  logic [WIDTH-1:0] u,
  input  logic [WIDTH-1:0] v,
  input  logic [KW-1:0]    k,
  output logic [WIDTH-1:0] u_nxt,
  output logic [WIDTH-1:0] v_nxt,
  output logic [KW-1:0]    k_nxt,
  output logic             term,
  output logic [WIDTH-1:0] gcd_val
);

  always_comb begin
    u_nxt   = u;
    v_nxt   = v;
    k_nxt   = k;
    term    = 1'b0;
    gcd_val = '0;
    if (u == '0) begin
      term    = 1'b1;
      gcd_val = v << k;
    end else if (v == '0) begin
      term    = 1'b1;
      gcd_val = u << k;
    end else if (!u[0] && !v[0]) begin
      u_nxt = u >> 1;
      v_nxt = v >> 1;
      k_nxt = k + 1'b1;
    end else if (!u[0]) begin
      u_nxt = u >> 1;
    end else if (!v[0]) begin
      v_nxt = v >> 1;
    end else if (u >= v) begin
      // Both odd: the difference is even, so one shift is always safe.
      u_nxt = (u - v) >> 1;
    end else begin
      u_nxt = (v - u) >> 1;
      v_nxt = u;
    end
  end

endmodule

`default_nettype wire

// File: rtl/gcd_stein_seq.sv
// ============================================================================
// Module  : gcd_stein_seq
// Purpose : Sequential binary GCD engine with valid/ready handshakes.
//           Optional REDUCE-cycle counter port under GCD_STEIN_CYCLE_CNT_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module gcd_stein_seq
  import gcd_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result
`ifdef GCD_STEIN_CYCLE_CNT_EN
  ,
  output logic [cnt_width(WIDTH)-1:0] cycles
`endif
);

  localparam int KW = k_width(WIDTH);

  gcd_state_t       state, state_nxt;
  logic [WIDTH-1:0] u, v;
  logic [KW-1:0]    k;
  logic [WIDTH-1:0] u_nxt, v_nxt, gcd_val;
  logic [KW-1:0]    k_nxt;
  logic             term;

  gcd_stein_step #(
    .WIDTH (WIDTH),
    .KW    (KW)
  ) u_step (
    .u       (u),
    .v       (v),
    .k       (k),
    .u_nxt   (u_nxt),
    .v_nxt   (v_nxt),
    .k_nxt   (k_nxt),
    .term    (term),
    .gcd_val (gcd_val)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = REDUCE;
      end
      REDUCE: if (term) state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      u      <= '0;
      v      <= '0;
      k      <= '0;
      result <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          u <= a;
          v <= b;
          k <= '0;
        end
        REDUCE: begin
          if (term) begin
            result <= gcd_val;
          end else begin
            u <= u_nxt;
            v <= v_nxt;
            k <= k_nxt;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef GCD_STEIN_CYCLE_CNT_EN
  // Counts every REDUCE cycle, terminal step included; frozen through DONE.
  always_ff @(posedge clk) begin
    if (rst)                             cycles <= '0;
    else if (state == IDLE && in_valid)  cycles <= '0;
    else if (state == REDUCE)            cycles <= cycles + 1'b1;
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_gcd_stein_seq.sv
// ============================================================================
// Module  : tb_gcd_stein_seq
// Purpose : Self-checking bench for gcd_stein_seq (WIDTH=8).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_gcd_stein_seq;
  import gcd_pkg::*;

  localparam int W       = 8;
  localparam int MAX_LAT = 2 * W + 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
`ifdef GCD_STEIN_CYCLE_CNT_EN
  logic [cnt_width(W)-1:0] cycles;
`endif

  gcd_stein_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
`ifdef GCD_STEIN_CYCLE_CNT_EN
    ,
    .cycles    (cycles)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] exp_result = '0;
  logic         exp_valid  = 1'b0;
  logic         prev_ov    = 1'b0;
  logic [W-1:0] prev_res   = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Reference: Euclid's algorithm, independent of the binary method.
  function automatic logic [63:0] model_gcd(input logic [63:0] x, input logic [63:0] y);
    logic [63:0] t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Compare process: whenever a result is presented it must match the model
  // and must not change while held.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_valid) chk("result_vs_model", {56'd0, result}, {56'd0, exp_result});
      if (prev_ov)   chk("result_stable", {56'd0, result}, {56'd0, prev_res});
    end
    prev_ov  <= !rst && out_valid;
    prev_res <= result;
  end

  task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input bit has_lit, input logic [W-1:0] lit, input int hold);
    int lat;
    logic [W-1:0] held;
    @(negedge clk);
    chk("in_ready_idle", {63'd0, in_ready}, 64'd1);
    out_ready = (hold == 0);
    in_valid  = 1'b1;
    a = ia;
    b = ib;
    @(posedge clk);
    exp_result = W'(model_gcd({56'd0, ia}, {56'd0, ib}));
    exp_valid  = 1'b1;
    #1;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      chk("in_ready_busy", {63'd0, in_ready}, 64'd0);
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid) begin
      chk("timeout_out_valid", {63'd0, out_valid}, 64'd1);
      exp_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      return;
    end
    chk("latency_bound", {63'd0, (lat <= MAX_LAT)}, 64'd1);
    if (ia == 0 || ib == 0) chk("latency_zero_operand", 64'(lat), 64'd2);
    if (has_lit) chk("result_literal", {56'd0, result}, {56'd0, lit});
`ifdef GCD_STEIN_CYCLE_CNT_EN
    chk("cycles", 64'(cycles), 64'(lat - 1));
`endif
    held = result;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      a = W'($urandom);
      b = W'($urandom);
      @(posedge clk);
      #1;
      chk("hold_out_valid", {63'd0, out_valid}, 64'd1);
      chk("hold_result", {56'd0, result}, {56'd0, held});
      chk("hold_in_ready", {63'd0, in_ready}, 64'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    exp_valid = 1'b0;
    chk("accepted_out_valid", {63'd0, out_valid}, 64'd0);
    chk("accepted_in_ready", {63'd0, in_ready}, 64'd1);
  endtask

  initial begin
    chk("model_48_18", model_gcd(64'd48, 64'd18), 64'd6);
    chk("model_0_7", model_gcd(64'd0, 64'd7), 64'd7);
    chk("model_9_0", model_gcd(64'd9, 64'd0), 64'd9);
    chk("model_0_0", model_gcd(64'd0, 64'd0), 64'd0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
    chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_result", {56'd0, result}, 64'd0);

    do_op(8'd48,  8'd18,  1, 8'd6,   0);
    do_op(8'd0,   8'd0,   1, 8'd0,   0);
    do_op(8'd0,   8'd7,   1, 8'd7,   0);
    do_op(8'd9,   8'd0,   1, 8'd9,   0);
    do_op(8'd255, 8'd255, 1, 8'd255, 0);
    do_op(8'd128, 8'd64,  1, 8'd64,  0);
    do_op(8'd255, 8'd1,   1, 8'd1,   0);
    do_op(8'd36,  8'd24,  1, 8'd12,  5);

    // Reset in the middle of an operation discards it.
    @(negedge clk);
    in_valid = 1'b1;
    a = 8'd200;
    b = 8'd150;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_result", {56'd0, result}, 64'd0);
    do_op(8'd21, 8'd14, 1, 8'd7, 0);

    for (int n = 0; n < 200; n++) begin
      logic [W-1:0] ra, rb;
      ra = ($urandom_range(0, 9) == 0) ? '0 : W'($urandom);
      rb = ($urandom_range(0, 9) == 0) ? '0 : W'($urandom);
      do_op(ra, rb, 0, '0, $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
